// File: rtl/filter_decimator.sv
// Block-average decimator for the low-pass filter cascade.
// Sums N = 2^DECIM_SHIFT consecutive samples and presents the block mean
// through a one-entry valid/ready output buffer. A result that arrives
// while the buffer is full and not being drained is dropped and latches
// the sticky OVERRUN flag.
// Optional feature: define FILTER_DECIMATOR_ROUND_EN for round-half-up
// averaging instead of the default truncating shift.
module filter_decimator #(
   parameter int DATA_BITS   = 28,
   parameter int DECIM_SHIFT = 4
) (
   input  logic                 CLK,
   input  logic                 RESET_N,
   input  logic                 CE,
   input  logic [DATA_BITS-1:0] IN_VALUE,
   output logic [DATA_BITS-1:0] OUT_VALUE,
   output logic                 OUT_VALID,
   input  logic                 OUT_READY,
   output logic                 OVERRUN
);

   localparam int ACC_BITS = DATA_BITS + DECIM_SHIFT;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } bufState;

   logic [ACC_BITS-1:0]    accum;
   logic [DECIM_SHIFT-1:0] count;
   logic [ACC_BITS:0]      blockSum;
   logic [ACC_BITS:0]      shifted;
   logic [DATA_BITS-1:0]   result;
   logic                   blockEnd;
   bufState                state;
   bufState                stateNext;
   logic                   load;
   logic                   drop;

   assign blockEnd = CE && (count == {DECIM_SHIFT{1'b1}});

   // Block total including the current sample, one bit wider than the
   // accumulator so the rounding offset can never wrap.
`ifdef FILTER_DECIMATOR_ROUND_EN
   localparam logic [ACC_BITS:0] HALF = {{ACC_BITS{1'b0}}, 1'b1} << (DECIM_SHIFT - 1);

   always_comb begin
      blockSum = {1'b0, accum} + {{(DECIM_SHIFT + 1){1'b0}}, IN_VALUE} + HALF;
      shifted  = blockSum >> DECIM_SHIFT;
      result   = (|shifted[ACC_BITS:DATA_BITS]) ? {DATA_BITS{1'b1}} : shifted[DATA_BITS-1:0];
   end
`else
   always_comb begin
      blockSum = {1'b0, accum} + {{(DECIM_SHIFT + 1){1'b0}}, IN_VALUE};
      shifted  = blockSum >> DECIM_SHIFT;
      result   = DATA_BITS'(shifted);
   end
`endif

   // Accumulate samples on each strobe; the last sample of a block clears
   // the sum so the next strobe starts a fresh block. The counter wraps
   // naturally because it is exactly DECIM_SHIFT bits wide.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         accum <= '0;
         count <= '0;
      end else if (CE) begin
         count <= count + 1'b1;
         if (blockEnd)
            accum <= '0;
         else
            accum <= accum + {{DECIM_SHIFT{1'b0}}, IN_VALUE};
      end
   end

   // Output buffer state register.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N)
         state <= EMPTY;
      else
         state <= stateNext;
   end

   // Decide whether a finished block is loaded, dropped, or the buffer drains.
   always_comb begin
      stateNext = state;
      load      = 1'b0;
      drop      = 1'b0;
      case (state)
         EMPTY: begin
            if (blockEnd) begin
               load      = 1'b1;
               stateNext = FULL;
            end
         end
         FULL: begin
            if (blockEnd) begin
               if (OUT_READY)
                  load = 1'b1;
               else
                  drop = 1'b1;
            end else if (OUT_READY) begin
               stateNext = EMPTY;
            end
         end
         default: stateNext = EMPTY;
      endcase
   end

   // Hold the presented result until a new one is loaded; remember any drop.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         OUT_VALUE <= '0;
         OVERRUN   <= 1'b0;
      end else begin
         if (load)
            OUT_VALUE <= result;
         if (drop)
            OVERRUN <= 1'b1;
      end
   end

   assign OUT_VALID = (state == FULL);

endmodule

// File: tb/tb_filter_decimator.sv
// Directed bench for filter_decimator with DATA_BITS=8, DECIM_SHIFT=2
// (blocks of four samples). Expected values are hand-computed for both
// the truncating and the FILTER_DECIMATOR_ROUND_EN build.
module tb_filter_decimator;

   logic       CLK = 1'b0;
   logic       RESET_N = 1'b0;
   logic       CE = 1'b0;
   logic [7:0] IN_VALUE = 8'd0;
   logic       OUT_READY = 1'b0;
   logic [7:0] OUT_VALUE;
   logic       OUT_VALID;
   logic       OVERRUN;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic       ce;
      logic [7:0] in;
      logic       rdy;
      logic       valid;
      logic [7:0] truncVal;
      logic [7:0] roundVal;
      logic       ovr;
   } vecType;

   vecType vecs [18];

   filter_decimator #(
      .DATA_BITS   (8),
      .DECIM_SHIFT (2)
   ) dut (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .CE        (CE),
      .IN_VALUE  (IN_VALUE),
      .OUT_VALUE (OUT_VALUE),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .OVERRUN   (OVERRUN)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 CLK = ~CLK;

   // Drive one cycle of inputs, then let the edge happen and settle.
   task automatic applyStimulus(input logic ce, input logic [7:0] in, input logic rdy);
      CE        = ce;
      IN_VALUE  = in;
      OUT_READY = rdy;
      @(posedge CLK);
      #1;
   endtask

   // Compare all three outputs as one check.
   task automatic checkOutput(input string name, input logic valid, input logic [7:0] value, input logic ovr);
      total++;
      if (OUT_VALID !== valid || OUT_VALUE !== value || OVERRUN !== ovr) begin
         bad++;
         $display("[TB] FAIL %s: got valid=%0b value=%0d overrun=%0b, want valid=%0b value=%0d overrun=%0b",
                  name, OUT_VALID, OUT_VALUE, OVERRUN, valid, value, ovr);
      end
   endtask

   initial begin
      logic [7:0] expVal;
      logic       ce;

      vecs[0]  = '{1'b1, 8'd10,  1'b1, 1'b0, 8'd0,   8'd0,   1'b0};
      vecs[1]  = '{1'b1, 8'd20,  1'b1, 1'b0, 8'd0,   8'd0,   1'b0};
      vecs[2]  = '{1'b1, 8'd30,  1'b1, 1'b0, 8'd0,   8'd0,   1'b0};
      vecs[3]  = '{1'b1, 8'd41,  1'b1, 1'b1, 8'd25,  8'd25,  1'b0};
      vecs[4]  = '{1'b1, 8'd10,  1'b1, 1'b0, 8'd25,  8'd25,  1'b0};
      vecs[5]  = '{1'b1, 8'd10,  1'b1, 1'b0, 8'd25,  8'd25,  1'b0};
      vecs[6]  = '{1'b1, 8'd10,  1'b1, 1'b0, 8'd25,  8'd25,  1'b0};
      vecs[7]  = '{1'b1, 8'd11,  1'b1, 1'b1, 8'd10,  8'd10,  1'b0};
      vecs[8]  = '{1'b0, 8'd0,   1'b1, 1'b0, 8'd10,  8'd10,  1'b0};
      vecs[9]  = '{1'b1, 8'd10,  1'b1, 1'b0, 8'd10,  8'd10,  1'b0};
      vecs[10] = '{1'b1, 8'd10,  1'b1, 1'b0, 8'd10,  8'd10,  1'b0};
      vecs[11] = '{1'b1, 8'd10,  1'b1, 1'b0, 8'd10,  8'd10,  1'b0};
      vecs[12] = '{1'b1, 8'd12,  1'b1, 1'b1, 8'd10,  8'd11,  1'b0};
      vecs[13] = '{1'b1, 8'd255, 1'b1, 1'b0, 8'd10,  8'd11,  1'b0};
      vecs[14] = '{1'b1, 8'd255, 1'b1, 1'b0, 8'd10,  8'd11,  1'b0};
      vecs[15] = '{1'b1, 8'd255, 1'b1, 1'b0, 8'd10,  8'd11,  1'b0};
      vecs[16] = '{1'b1, 8'd255, 1'b1, 1'b1, 8'd255, 8'd255, 1'b0};
      vecs[17] = '{1'b0, 8'd0,   1'b1, 1'b0, 8'd255, 8'd255, 1'b0};

      #2;
      checkOutput("reset-state", 1'b0, 8'd0, 1'b0);
      @(negedge CLK);
      RESET_N = 1'b1;

      for (int i = 0; i < 18; i++) begin
         applyStimulus(vecs[i].ce, vecs[i].in, vecs[i].rdy);
`ifdef FILTER_DECIMATOR_ROUND_EN
         expVal = vecs[i].roundVal;
`else
         expVal = vecs[i].truncVal;
`endif
         checkOutput($sformatf("vec%0d", i), vecs[i].valid, expVal, vecs[i].ovr);
      end

      // Two block ends with the consumer stalled: first result held, second dropped.
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'd4, 1'b0);
      checkOutput("stall-first", 1'b1, 8'd4, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'd8, 1'b0);
      checkOutput("stall-hold", 1'b1, 8'd4, 1'b0);
      applyStimulus(1'b1, 8'd8, 1'b0);
      checkOutput("stall-drop", 1'b1, 8'd4, 1'b1);
      applyStimulus(1'b0, 8'd0, 1'b1);
      checkOutput("stall-drain", 1'b0, 8'd4, 1'b1);
      applyStimulus(1'b0, 8'd0, 1'b0);
      checkOutput("overrun-sticky", 1'b0, 8'd4, 1'b1);

      RESET_N = 1'b0;
      #2;
      checkOutput("reset-clears", 1'b0, 8'd0, 1'b0);
      @(negedge CLK);
      RESET_N = 1'b1;

      // Drain and reload on the same edge: no drop.
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'd20, 1'b0);
      checkOutput("swap-first", 1'b1, 8'd20, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'd40, 1'b0);
      checkOutput("swap-hold", 1'b1, 8'd20, 1'b0);
      applyStimulus(1'b1, 8'd40, 1'b1);
      checkOutput("swap-load", 1'b1, 8'd40, 1'b0);
      applyStimulus(1'b0, 8'd0, 1'b1);
      checkOutput("swap-drain", 1'b0, 8'd40, 1'b0);

      // Asynchronous reset mid-block discards the partial sum.
      applyStimulus(1'b1, 8'd100, 1'b1);
      applyStimulus(1'b1, 8'd100, 1'b1);
      checkOutput("partial", 1'b0, 8'd40, 1'b0);
      #2;
      RESET_N = 1'b0;
      #1;
      checkOutput("async-reset", 1'b0, 8'd0, 1'b0);
      CE       = 1'b1;
      IN_VALUE = 8'd50;
      @(posedge CLK);
      #1;
      checkOutput("ce-in-reset", 1'b0, 8'd0, 1'b0);
      @(negedge CLK);
      RESET_N = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'd8, 1'b1);
      checkOutput("post-reset-3", 1'b0, 8'd0, 1'b0);
      applyStimulus(1'b1, 8'd8, 1'b1);
      checkOutput("post-reset-4", 1'b1, 8'd8, 1'b0);
      applyStimulus(1'b0, 8'd0, 1'b1);
      checkOutput("post-reset-drain", 1'b0, 8'd8, 1'b0);

      // Strobe every other cycle; ignored samples carry a different value.
      for (int i = 0; i < 16; i++) begin
         ce = (i % 2 == 0);
         applyStimulus(ce, ce ? 8'd100 : 8'd200, 1'b1);
         checkOutput($sformatf("toggle%0d", i), (i % 8 == 6), (i >= 6) ? 8'd100 : 8'd8, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
